branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Decode-stage branch resolution controller for the 5-stage MIPS-32 pipeline. It selects forwarded branch operands, detects operand hazards and stalls decode until they clear, and drives the external branch comparator (cmp_*/cmp_y). It produces the taken/target decision, the link write for BGEZAL/BLTZAL, and holds a resolved decision stable while the pipeline is frozen by other stall sources. It also keeps branch performance counters.

## Interface
- CNT_W, 32, width of performance counters
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- br_valid  in  1  ID holds a conditional branch (BEQ/BNE/BGTZ/BLEZ/REGIMM)
- br_op  in  6  opcode field
- br_rt  in  5  rt field (REGIMM sub-code)
- rs_addr, rt_addr  in  5 each  source registers; rt_addr used only for BEQ/BNE
- rf_a, rf_b  in  32 each  register-file reads (WB bypass already applied)
- pc_plus4  in  32  PC of branch + 4
- br_offset  in  32  sign-extended imm, already shifted left 2
- ex_wreg, ex_waddr  in  1, 5  EX-stage register write
- mem_wreg, mem_waddr, mem_is_load  in  1, 5, 1  MEM-stage register write
- mem_result  in  32  MEM-stage ALU result
- ext_stall  in  1  decode frozen by another source (e.g. divider, memory)
- flush  in  1  exception flush of decode
- cmp_a, cmp_b  out  32 each  comparator operands
- cmp_op, cmp_rt  out  6, 5  comparator selectors (copies of br_op, br_rt)
- cmp_y  in  1  comparator result (combinational)
- stall_d  out  1  hold F and D for an operand hazard
- pc_branch  out  1  load PC with br_target
- br_target  out  32  pc_plus4 + br_offset, mod 2^32
- link_we, link_data  out  1, 32  write $31 with pc_plus4+4 (AL variants)
- br_cnt, taken_cnt  out  CNT_W each  resolved / taken branch counters

## Operation
- Operand needed: rs always; rt only when br_op is BEQ or BNE. A source whose address is $0 is never hazarded and never forwarded.
- hazard = needed source matches ex_waddr with ex_wreg=1, OR matches mem_waddr with mem_wreg=1 and mem_is_load=1.
- Forwarding: a needed source that matches mem_waddr with mem_wreg=1 and mem_is_load=0 takes mem_result. Otherwise it takes rf_a/rf_b.
- cmp_a/cmp_b carry the forwarded values at all times.
- FSM states: IDLE, HAZ, DONE.
- IDLE:
  - br_valid & hazard -> HAZ.
  - br_valid & !hazard -> resolve this cycle, then go to DONE if ext_stall, else stay IDLE.
- HAZ:
  - flush -> IDLE, with no resolve.
  - !hazard -> resolve this cycle, then go to DONE if ext_stall, else IDLE.
  - Otherwise stay in HAZ.
- DONE:
  - flush or !ext_stall -> IDLE.
  - br_valid is guaranteed held while in DONE.
- stall_d = br_valid & hazard & state≠DONE.
- Resolve cycle:
  - pc_branch = cmp_y.
  - taken_q <= cmp_y.
  - br_cnt += 1; taken_cnt += cmp_y.
  - link_we = 1 if br_op = REGIMM and br_rt ∈ {BGEZAL, BLTZAL}, independent of cmp_y.
- In DONE:
  - pc_branch = taken_q.
  - link_we = 0: link is written exactly once per branch.
  - Counters do not advance.
- flush in IDLE with br_valid suppresses resolution. pc_branch, link_we and the counters stay inactive that cycle.
- Counters wrap modulo 2^CNT_W.
- br_target is combinational and always valid.

## Timing
- Reset (resetn=0, asynchronous): state=IDLE, taken_q=0, br_cnt=0, taken_cnt=0.
  - stall_d, pc_branch and link_we are 0 while reset is asserted.
- Resolution has zero latency: decision in the same cycle the hazard-free branch is presented. The delay slot proceeds normally.
- EX ALU hazard: 1 stall cycle. Load in EX: 2 stall cycles. Load in MEM: 1 stall cycle.
- Counter updates are visible the cycle after resolve.
- flush has priority over resolve and over all transitions.
- resetn deasserted mid-HAZ or mid-DONE: returns to IDLE; no pending link write or taken decision is retained.

## Test plan
- No hazard: BEQ, rf_a=rf_b=5, ext_stall=0 -> stall_d=0, pc_branch=1 same cycle, br_target=pc_plus4+br_offset; br_cnt=1, taken_cnt=1 next cycle.
- EX hazard: BNE with rs=$8, ex_wreg=1, ex_waddr=8 -> stall_d=1 for 1 cycle. Next cycle mem_result=7 forwarded to cmp_a, rf_b=3 -> pc_branch=1, stall_d=0.
- Load hazard: BGTZ, rs=$4 loaded in EX -> 2 stall cycles, then resolves with rf_a via WB bypass. Forwarding from $0 never hazards or forwards even if ex_waddr=0.
- Ext stall: BGEZAL, rf_a=0, ext_stall=1 for 3 cycles -> link_we=1 exactly once with link_data=pc_plus4+4. pc_branch=1 for all 4 cycles; br_cnt increments by 1 only.
- Flush in HAZ: BLEZ hazarded, flush=1 -> IDLE; no pc_branch, no link_we, counters unchanged.
- Reset: resetn=0 in DONE -> all outputs 0 and counters 0 immediately. Counter wrap: CNT_W=4 with 16 resolves -> br_cnt=0.

Source files
------------

// File: rtl/branch_ctrl.sv
// Decode-stage branch resolution: operand forwarding, hazard stall, taken/target decision,
// AL link write, hold of a resolved decision across external stalls, and branch counters.
module branch_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             br_valid,
    input  logic [5:0]       br_op,
    input  logic [4:0]       br_rt,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    input  logic [31:0]      rf_a,
    input  logic [31:0]      rf_b,
    input  logic [31:0]      pc_plus4,
    input  logic [31:0]      br_offset,
    input  logic             ex_wreg,
    input  logic [4:0]       ex_waddr,
    input  logic             mem_wreg,
    input  logic [4:0]       mem_waddr,
    input  logic             mem_is_load,
    input  logic [31:0]      mem_result,
    input  logic             ext_stall,
    input  logic             flush,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    output logic [5:0]       cmp_op,
    output logic [4:0]       cmp_rt,
    input  logic             cmp_y,
    output logic             stall_d,
    output logic             pc_branch,
    output logic [31:0]      br_target,
    output logic             link_we,
    output logic [31:0]      link_data,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    typedef enum logic [1:0] {IDLE, HAZ, DONE} state_t;

    state_t state;
    logic   taken_q;
    logic   need_rt;
    logic   haz_rs;
    logic   haz_rt;
    logic   hazard;
    logic   fwd_rs;
    logic   fwd_rt;
    logic   resolve;
    logic   is_link;

    // $0 is hardwired, so it can neither hazard nor be forwarded.
    always_comb begin
        need_rt = (br_op == OP_BEQ) || (br_op == OP_BNE);
        haz_rs  = (rs_addr != 5'd0) &&
                  ((ex_wreg && (ex_waddr == rs_addr)) ||
                   (mem_wreg && mem_is_load && (mem_waddr == rs_addr)));
        haz_rt  = need_rt && (rt_addr != 5'd0) &&
                  ((ex_wreg && (ex_waddr == rt_addr)) ||
                   (mem_wreg && mem_is_load && (mem_waddr == rt_addr)));
        hazard  = haz_rs || haz_rt;
        fwd_rs  = (rs_addr != 5'd0) && mem_wreg && !mem_is_load && (mem_waddr == rs_addr);
        fwd_rt  = need_rt && (rt_addr != 5'd0) && mem_wreg && !mem_is_load &&
                  (mem_waddr == rt_addr);
        is_link = (br_op == OP_REGIMM) && ((br_rt == RT_BLTZAL) || (br_rt == RT_BGEZAL));
    end

    assign cmp_a     = fwd_rs ? mem_result : rf_a;
    assign cmp_b     = fwd_rt ? mem_result : rf_b;
    assign cmp_op    = br_op;
    assign cmp_rt    = br_rt;
    assign br_target = pc_plus4 + br_offset;
    assign link_data = pc_plus4 + 32'd4;

    // Outputs are gated by resetn so nothing fires while reset is held.
    assign resolve   = resetn && br_valid && !hazard && !flush && (state != DONE);
    assign stall_d   = resetn && br_valid && hazard && (state != DONE);
    assign pc_branch = resetn && (resolve ? cmp_y : ((state == DONE) && taken_q));
    assign link_we   = resolve && is_link;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            taken_q   <= 1'b0;
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            if (resolve) begin
                br_cnt    <= br_cnt + CNT_W'(1);
                taken_cnt <= taken_cnt + CNT_W'(cmp_y);
                taken_q   <= cmp_y;
            end
            case (state)
                IDLE: begin
                    if (br_valid && !flush) begin
                        if (hazard)
                            state <= HAZ;
                        else if (ext_stall)
                            state <= DONE;
                    end
                end
                HAZ: begin
                    if (flush || !br_valid)
                        state <= IDLE;
                    else if (!hazard)
                        state <= ext_stall ? DONE : IDLE;
                end
                DONE: begin
                    if (flush || !ext_stall)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a cycle model of the branch rules acts as the comparator
// and scoreboard, plus hand-computed literal checks at key points of each scenario.
module tb_branch_ctrl;
    localparam logic [5:0] REGIMM = 6'h01;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] BLEZ   = 6'h06;
    localparam logic [5:0] BGTZ   = 6'h07;

    logic        clk = 1'b0;
    logic        resetn;
    logic        br_valid;
    logic [5:0]  br_op;
    logic [4:0]  br_rt, rs_addr, rt_addr;
    logic [31:0] rf_a, rf_b, pc_plus4, br_offset;
    logic        ex_wreg;
    logic [4:0]  ex_waddr;
    logic        mem_wreg;
    logic [4:0]  mem_waddr;
    logic        mem_is_load;
    logic [31:0] mem_result;
    logic        ext_stall, flush, cmp_y;

    logic [31:0] cmp_a, cmp_b, br_target, link_data, br_cnt, taken_cnt;
    logic [5:0]  cmp_op;
    logic [4:0]  cmp_rt;
    logic        stall_d, pc_branch, link_we;

    logic [31:0] cmp_a4, cmp_b4, br_target4, link_data4;
    logic [3:0]  br_cnt4, taken_cnt4;
    logic [5:0]  cmp_op4;
    logic [4:0]  cmp_rt4;
    logic        stall_d4, pc_branch4, link_we4;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    branch_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .br_valid(br_valid), .br_op(br_op), .br_rt(br_rt),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rf_a(rf_a), .rf_b(rf_b), .pc_plus4(pc_plus4),
        .br_offset(br_offset), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .mem_wreg(mem_wreg),
        .mem_waddr(mem_waddr), .mem_is_load(mem_is_load), .mem_result(mem_result),
        .ext_stall(ext_stall), .flush(flush), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_op(cmp_op),
        .cmp_rt(cmp_rt), .cmp_y(cmp_y), .stall_d(stall_d), .pc_branch(pc_branch),
        .br_target(br_target), .link_we(link_we), .link_data(link_data), .br_cnt(br_cnt),
        .taken_cnt(taken_cnt)
    );

    branch_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .br_valid(br_valid), .br_op(br_op), .br_rt(br_rt),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rf_a(rf_a), .rf_b(rf_b), .pc_plus4(pc_plus4),
        .br_offset(br_offset), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .mem_wreg(mem_wreg),
        .mem_waddr(mem_waddr), .mem_is_load(mem_is_load), .mem_result(mem_result),
        .ext_stall(ext_stall), .flush(flush), .cmp_a(cmp_a4), .cmp_b(cmp_b4), .cmp_op(cmp_op4),
        .cmp_rt(cmp_rt4), .cmp_y(cmp_y), .stall_d(stall_d4), .pc_branch(pc_branch4),
        .br_target(br_target4), .link_we(link_we4), .link_data(link_data4), .br_cnt(br_cnt4),
        .taken_cnt(taken_cnt4)
    );

    // ---------------- behavioural model ----------------
    logic        m_held = 1'b0;
    logic        m_taken = 1'b0;
    logic [31:0] m_br = '0;
    logic [31:0] m_tk = '0;
    logic        uses_rt, exp_haz, exp_y, exp_res, exp_link;
    logic [31:0] exp_a, exp_b;

    function automatic logic busy(input logic [4:0] a);
        return (a != 5'd0) && ((ex_wreg && ex_waddr == a) ||
                               (mem_wreg && mem_is_load && mem_waddr == a));
    endfunction

    function automatic logic [31:0] value_of(input logic [4:0] a, input logic [31:0] rf);
        if (a != 5'd0 && mem_wreg && !mem_is_load && mem_waddr == a) return mem_result;
        return rf;
    endfunction

    function automatic logic taken_rule(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (op)
            BEQ:    return a == b;
            BNE:    return a != b;
            BLEZ:   return $signed(a) <= 0;
            BGTZ:   return $signed(a) > 0;
            REGIMM: return rt[0] ? ($signed(a) >= 0) : ($signed(a) < 0);
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        uses_rt  = (br_op == BEQ) || (br_op == BNE);
        exp_haz  = busy(rs_addr) || (uses_rt && busy(rt_addr));
        exp_a    = value_of(rs_addr, rf_a);
        exp_b    = uses_rt ? value_of(rt_addr, rf_b) : rf_b;
        exp_y    = taken_rule(br_op, br_rt, exp_a, exp_b);
        exp_res  = resetn && br_valid && !exp_haz && !flush && !m_held;
        exp_link = exp_res && br_op == REGIMM && (br_rt == 5'h10 || br_rt == 5'h11);
    end

    assign cmp_y = exp_y;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_held <= 1'b0; m_taken <= 1'b0; m_br <= '0; m_tk <= '0;
        end else if (exp_res) begin
            m_br <= m_br + 32'd1;
            m_tk <= m_tk + 32'(exp_y);
            m_held <= ext_stall;
            m_taken <= exp_y;
        end else if (m_held && (flush || !ext_stall)) begin
            m_held <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("stall_d", 32'(stall_d), 32'(resetn && br_valid && exp_haz && !m_held));
            check("pc_branch", 32'(pc_branch), 32'(resetn && (exp_res ? exp_y : m_held && m_taken)));
            check("link_we", 32'(link_we), 32'(exp_link));
            check("br_target", br_target, pc_plus4 + br_offset);
            check("link_data", link_data, pc_plus4 + 32'd4);
            check("cmp_a", cmp_a, exp_a);
            check("cmp_b", cmp_b, exp_b);
            check("cmp_sel", {21'd0, cmp_op, cmp_rt}, {21'd0, br_op, br_rt});
            check("br_cnt", br_cnt, m_br);
            check("taken_cnt", taken_cnt, m_tk);
            check("w4_ctrl", {29'd0, stall_d4, pc_branch4, link_we4},
                  {29'd0, resetn && br_valid && exp_haz && !m_held,
                   resetn && (exp_res ? exp_y : m_held && m_taken), exp_link});
            check("w4_data", cmp_a4 ^ cmp_b4 ^ br_target4 ^ link_data4 ^ {21'd0, cmp_op4, cmp_rt4},
                  exp_a ^ exp_b ^ (pc_plus4 + br_offset) ^ (pc_plus4 + 32'd4) ^ {21'd0, br_op, br_rt});
            check("w4_cnt", {24'd0, br_cnt4, taken_cnt4}, {24'd0, m_br[3:0], m_tk[3:0]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        br_valid = 0; br_op = BEQ; br_rt = 0; rs_addr = 0; rt_addr = 0;
        rf_a = 0; rf_b = 0; pc_plus4 = 32'h0000_1000; br_offset = 0;
        ex_wreg = 0; ex_waddr = 0; mem_wreg = 0; mem_waddr = 0; mem_is_load = 0;
        mem_result = 0; ext_stall = 0; flush = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic [5:0] op, input logic [4:0] rt_code, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [31:0] a, input logic [31:0] b);
        br_valid = 1; br_op = op; br_rt = rt_code; rs_addr = rs; rt_addr = rt; rf_a = a; rf_b = b;
    endtask

    int link_seen;

    initial begin
        resetn = 1'b1;
        idle_inputs();
        #1 resetn = 1'b0;
        chk_on = 1'b1;
        branch(BEQ, 0, 1, 2, 5, 5);
        #1;
        check("rst_pc_branch", 32'(pc_branch), 0);
        check("rst_cnt", br_cnt, 0);
        cyc(); cyc();

        // no hazard, taken BEQ
        resetn = 1'b1;
        branch(BEQ, 0, 1, 2, 5, 5); pc_plus4 = 32'h100; br_offset = 32'h20;
        #1;
        check("nohaz_stall", 32'(stall_d), 0);
        check("nohaz_pc_branch", 32'(pc_branch), 1);
        check("nohaz_target", br_target, 32'h120);
        cyc();
        idle_inputs();
        #1;
        check("nohaz_br_cnt", br_cnt, 1);
        check("nohaz_taken_cnt", taken_cnt, 1);
        cyc();

        // EX ALU hazard on rs, then forwarded from MEM
        branch(BNE, 0, 8, 9, 0, 3); ex_wreg = 1; ex_waddr = 8;
        #1;
        check("exhaz_stall", 32'(stall_d), 1);
        check("exhaz_pc_branch", 32'(pc_branch), 0);
        cyc();
        ex_wreg = 0; mem_wreg = 1; mem_waddr = 8; mem_result = 7;
        #1;
        check("exhaz_fwd_a", cmp_a, 7);
        check("exhaz_resolve", {30'd0, stall_d, pc_branch}, 32'b01);
        cyc();

        // load in EX: two stall cycles, then WB bypass value
        idle_inputs();
        branch(BGTZ, 0, 4, 4, 0, 0); ex_wreg = 1; ex_waddr = 4;
        #1; check("ld_stall1", 32'(stall_d), 1);
        cyc();
        ex_wreg = 0; mem_wreg = 1; mem_waddr = 4; mem_is_load = 1;
        #1; check("ld_stall2", 32'(stall_d), 1);
        cyc();
        mem_wreg = 0; mem_is_load = 0; rf_a = 9;
        #1; check("ld_resolve", {30'd0, stall_d, pc_branch}, 32'b01);
        cyc();

        // $0 never hazards or forwards
        idle_inputs();
        branch(BEQ, 0, 0, 0, 0, 0); ex_wreg = 1; ex_waddr = 0;
        mem_wreg = 1; mem_waddr = 0; mem_result = 32'h55;
        #1;
        check("r0_stall", 32'(stall_d), 0);
        check("r0_cmp_a", cmp_a, 0);
        cyc();

        // BGEZAL under external stall: one link write, decision held
        idle_inputs();
        branch(REGIMM, 5'h11, 2, 0, 0, 0); pc_plus4 = 32'h200;
        link_seen = 0;
        for (int i = 0; i < 4; i++) begin
            ext_stall = (i < 3);
            #1;
            link_seen += int'(link_we);
            check("al_pc_branch", 32'(pc_branch), 1);
            if (i == 0) check("al_link_data", link_data, 32'h204);
            cyc();
        end
        idle_inputs();
        #1;
        check("al_link_once", 32'(link_seen), 1);
        check("al_br_cnt", br_cnt, 5);
        check("al_taken_cnt", taken_cnt, 5);
        cyc();

        // flush while hazarded, then flush in IDLE
        branch(BLEZ, 0, 3, 0, 0, 0); ex_wreg = 1; ex_waddr = 3;
        #1; check("fl_stall", 32'(stall_d), 1);
        cyc();
        ex_wreg = 0; flush = 1;
        #1; check("fl_haz_out", {30'd0, pc_branch, link_we}, 0);
        cyc();
        branch(BEQ, 0, 1, 2, 6, 6);
        #1; check("fl_idle_pc_branch", 32'(pc_branch), 0);
        cyc();
        idle_inputs();
        #1; check("fl_br_cnt", br_cnt, 5);
        cyc();

        // reset while holding a decision
        branch(BEQ, 0, 1, 2, 6, 6); ext_stall = 1;
        cyc();
        #1; check("done_hold", 32'(pc_branch), 1);
        #1 resetn = 1'b0;
        #1;
        check("rstdone_out", {29'd0, stall_d, pc_branch, link_we}, 0);
        check("rstdone_cnt", br_cnt | taken_cnt, 0);
        cyc();
        resetn = 1'b1; idle_inputs();
        #1; check("rstdone_after", 32'(pc_branch), 0);
        cyc();

        // 16 resolves wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            branch(BEQ, 0, 1, 2, 32'(i), 32'(i));
            cyc();
        end
        idle_inputs();
        #1;
        check("wrap_w4", 32'(br_cnt4), 0);
        check("wrap_w32", br_cnt, 16);
        cyc();

        // condition variety, rt-only hazards and rt forwarding
        branch(BNE, 0, 1, 2, 4, 4);
        #1; check("bne_equal", 32'(pc_branch), 0);
        cyc();
        branch(BGTZ, 0, 1, 2, 32'hFFFF_FFFF, 0); ex_wreg = 1; ex_waddr = 2;
        #1; check("bgtz_neg_rt_ignored", {30'd0, stall_d, pc_branch}, 0);
        cyc();
        idle_inputs();
        branch(REGIMM, 5'h00, 1, 0, 32'h8000_0000, 0);
        #1; check("bltz_neg", 32'(pc_branch), 1);
        cyc();
        branch(REGIMM, 5'h10, 1, 0, 1, 0);
        #1; check("bltzal_nt", {30'd0, pc_branch, link_we}, 32'b01);
        cyc();
        branch(BEQ, 0, 1, 2, 5, 9); mem_wreg = 1; mem_waddr = 2; mem_is_load = 1;
        #1; check("beq_rt_load", 32'(stall_d), 1);
        cyc();
        mem_is_load = 0; mem_result = 5;
        #1;
        check("beq_rt_fwd", cmp_b, 5);
        check("beq_rt_taken", 32'(pc_branch), 1);
        cyc();
        idle_inputs();
        cyc(); cyc();
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
